// File: rtl/round_robin_dispatcher_pkg.sv
// Shared sizing and channel-index type for the round-robin write dispatcher.
package round_robin_dispatcher_pkg;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/dispatch_fifo.sv
// Single-channel synchronous FIFO with a registered, one-cycle read response.
module dispatch_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic             ren,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Flags are decoded from the count register, so they reflect pre-edge state.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wen && !full;
  assign do_rd = ren && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_wr) - CW'(do_rd);
      valid <= do_rd;
      dout  <= do_rd ? mem[rd_ptr] : '0;
    end
  end

  // Storage carries no reset; contents are only visible through count.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/round_robin_dispatcher.sv
// Spreads one write stream over four FIFOs in rotation, skipping full channels.
module round_robin_dispatcher
  import round_robin_dispatcher_pkg::*;
#(
  parameter int unsigned WIDTH  = round_robin_dispatcher_pkg::WIDTH,
  parameter int unsigned DEPTH  = round_robin_dispatcher_pkg::DEPTH,
  parameter int unsigned NUM_CH = round_robin_dispatcher_pkg::NUM_CH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wen,
  input  logic [WIDTH-1:0]  din,
  input  logic [NUM_CH-1:0] ren,
  output logic [WIDTH-1:0]  dout0,
  output logic [WIDTH-1:0]  dout1,
  output logic [WIDTH-1:0]  dout2,
  output logic [WIDTH-1:0]  dout3,
  output logic [NUM_CH-1:0] valid,
  output logic [NUM_CH-1:0] full,
  output logic [NUM_CH-1:0] empty,
  output ch_idx_t           ptr,
  output logic              drop
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NUM_CH-1:0] wen_vec;
  logic [CW-1:0]     count    [NUM_CH];
  logic [WIDTH-1:0]  dout_arr [NUM_CH];
  ch_idx_t           target;
  ch_idx_t           cand;
  logic              found;

  // Priority scan from ptr for the first channel with room.
  always_comb begin
    target  = '0;
    cand    = '0;
    found   = 1'b0;
    wen_vec = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      cand = ptr + ch_idx_t'(i);
      if (!found && (count[cand] != CW'(DEPTH))) begin
        found  = 1'b1;
        target = cand;
      end
    end
    if (wen && found) wen_vec[target] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      drop <= 1'b0;
    end else begin
      drop <= wen && !found;
      if (wen && found) ptr <= target + ch_idx_t'(1);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dispatch_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .wen   (wen_vec[g]),
      .ren   (ren[g]),
      .din   (din),
      .dout  (dout_arr[g]),
      .valid (valid[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .count (count[g])
    );
  end

  assign dout0 = dout_arr[0];
  assign dout1 = dout_arr[1];
  assign dout2 = dout_arr[2];
  assign dout3 = dout_arr[3];

endmodule
